// File: rtl/instruction_fetch.sv
// Purpose : IF stage. Owns the PC, drives the instruction-memory read port and loads the IF/ID register.
// Latency : an instruction acked in cycle N is visible in IF/ID after edge N (one per cycle with zero-wait memory).
// Backpres: stall_en freezes IF/ID; data acked during a stall parks in a one-entry hold buffer (imem_req drops).
//
// Ports:
//   clk, clrn                  clock, synchronous active-low reset
//   stall_en                   decode stall, freezes IF/ID
//   pcsource, bpc, jpc, ra     redirect select and targets from decode
//   imem_req/addr/rdata/ack    instruction-memory read port (one outstanding request)
//   if_pc4, if_inst, if_valid  IF/ID register contents
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        stall_en,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] jpc,
    input  logic [31:0] ra,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] if_pc4,
    output logic [31:0] if_inst,
    output logic        if_valid
);

    typedef enum logic [1:0] {
        S_RST   = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_DROP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] drop_addr_q, drop_addr_d;
    logic [31:0] hold_pc4_q, hold_pc4_d;
    logic [31:0] hold_inst_q, hold_inst_d;
    logic [31:0] if_pc4_q, if_pc4_d;
    logic [31:0] if_inst_q, if_inst_d;
    logic        if_valid_q, if_valid_d;

    logic        advance;
    logic        redirect;
    logic [31:0] target;
    logic [31:0] pc_plus4;

    assign advance  = ~stall_en;
    // Only a real instruction in IF/ID can redirect; a bubble never does.
    assign redirect = advance & if_valid_q & (pcsource != 2'b00);
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        case (pcsource)
            2'b01:   target = bpc;
            2'b10:   target = ra;
            2'b11:   target = jpc;
            default: target = pc_plus4;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_q     <= S_RST;
            pc_q        <= RESET_PC;
            drop_addr_q <= 32'd0;
            hold_pc4_q  <= 32'd0;
            hold_inst_q <= NOP_INST;
            if_pc4_q    <= 32'd0;
            if_inst_q   <= NOP_INST;
            if_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_addr_q <= drop_addr_d;
            hold_pc4_q  <= hold_pc4_d;
            hold_inst_q <= hold_inst_d;
            if_pc4_q    <= if_pc4_d;
            if_inst_q   <= if_inst_d;
            if_valid_q  <= if_valid_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_addr_d = drop_addr_q;
        hold_pc4_d  = hold_pc4_q;
        hold_inst_d = hold_inst_q;
        if_pc4_d    = if_pc4_q;
        if_inst_d   = if_inst_q;
        if_valid_d  = if_valid_q;

        // Whenever decode consumes IF/ID, a bubble goes in unless a case below loads an instruction.
        if (advance) begin
            if_inst_d  = NOP_INST;
            if_valid_d = 1'b0;
        end

        case (state_q)
            S_RST: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    if (redirect) begin
                        pc_d = target;
                    end else if (advance) begin
                        if_pc4_d   = pc_plus4;
                        if_inst_d  = imem_rdata;
                        if_valid_d = 1'b1;
                        pc_d       = pc_plus4;
                    end else begin
                        hold_pc4_d  = pc_plus4;
                        hold_inst_d = imem_rdata;
                        pc_d        = pc_plus4;
                        state_d     = S_HOLD;
                    end
                end else if (redirect) begin
                    // The request already on the bus must complete before the new one can go out.
                    drop_addr_d = pc_q;
                    pc_d        = target;
                    state_d     = S_DROP;
                end
            end
            S_HOLD: begin
                if (advance) begin
                    state_d = S_FETCH;
                    if (redirect) begin
                        pc_d = target;
                    end else begin
                        if_pc4_d   = hold_pc4_q;
                        if_inst_d  = hold_inst_q;
                        if_valid_d = 1'b1;
                    end
                end
            end
            S_DROP: begin
                if (imem_ack) begin
                    state_d = S_FETCH;
                end
            end
        endcase
    end

    // Outputs
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = pc_q;
        case (state_q)
            S_FETCH: imem_req = 1'b1;
            S_DROP: begin
                imem_req  = 1'b1;
                imem_addr = drop_addr_q;
            end
            default: ;
        endcase
    end

    assign if_pc4   = if_pc4_q;
    assign if_inst  = if_inst_q;
    assign if_valid = if_valid_q;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

    localparam logic [31:0] NOP = 32'h0000_0000;
    localparam logic [31:0] TAG = 32'hA000_0000;

    logic        clk = 1'b0;
    logic        clrn;
    logic        stall_en;
    logic [1:0]  pcsource;
    logic [31:0] bpc, jpc, ra;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic [31:0] if_pc4;
    logic [31:0] if_inst;
    logic        if_valid;

    int total = 0;
    int bad   = 0;

    instruction_fetch #(
        .RESET_PC(32'h0000_0000),
        .NOP_INST(32'h0000_0000)
    ) dut (
        .clk       (clk),
        .clrn      (clrn),
        .stall_en  (stall_en),
        .pcsource  (pcsource),
        .bpc       (bpc),
        .jpc       (jpc),
        .ra        (ra),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_rdata(imem_rdata),
        .imem_ack  (imem_ack),
        .if_pc4    (if_pc4),
        .if_inst   (if_inst),
        .if_valid  (if_valid)
    );

    always #5 clk = ~clk;

    // Instruction memory: mem[a] = a | A000_0000, ack after mem_lat request cycles (1 = same cycle).
    int mem_cnt = 0;
    int mem_lat = 1;
    int lat_cfg = 1;
    bit rnd_lat = 1'b0;

    assign imem_rdata = imem_addr | TAG;
    assign imem_ack   = imem_req && (mem_cnt == mem_lat - 1);

    always @(posedge clk) begin
        if (!clrn || !imem_req || imem_ack) begin
            mem_cnt <= 0;
            mem_lat <= rnd_lat ? int'($urandom_range(1, 3)) : lat_cfg;
        end else begin
            mem_cnt <= mem_cnt + 1;
        end
    end

    typedef struct {
        logic        stall;
        logic [1:0]  ps;
        logic [31:0] tgt;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_vld;
        logic [31:0] exp_inst;
        logic [31:0] exp_pc4;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic [1:0] p, input logic [31:0] t,
                                input logic rq, input logic [31:0] ad, input logic v,
                                input logic [31:0] in, input logic [31:0] p4);
        vec_t r;
        r.stall = s; r.ps = p; r.tgt = t;
        r.exp_req = rq; r.exp_addr = ad; r.exp_vld = v; r.exp_inst = in; r.exp_pc4 = p4;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        clrn     = 1'b0;
        stall_en = 1'b0;
        pcsource = 2'b00;
        bpc = 32'h0; jpc = 32'h0; ra = 32'h0;
        step();
        step();
        clrn = 1'b1;
    endtask

    // Drive the selected target on its own bus and junk on the others so a wrong mux leg shows up.
    task automatic drive(input logic s, input logic [1:0] p, input logic [31:0] t);
        stall_en = s;
        pcsource = p;
        bpc = (p == 2'b01) ? t : 32'h0BAD_0010;
        ra  = (p == 2'b10) ? t : 32'h0BAD_0020;
        jpc = (p == 2'b11) ? t : 32'h0BAD_0030;
    endtask

    vec_t tv[17];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          found;
        bit          saw_wrong;
        int          consumed;
        bit          prev_pend;
        logic [31:0] prev_addr;
        logic [31:0] exp_pc;
        logic [31:0] nxt;

        // zero-wait directed vectors, applied from FETCH at pc 0 with an empty IF/ID
        tv[0]  = mk(0, 2'd0, 32'h0,         1, 32'h4,         1, TAG | 32'h0,  32'h4);
        tv[1]  = mk(0, 2'd0, 32'h0,         1, 32'h8,         1, TAG | 32'h4,  32'h8);
        tv[2]  = mk(0, 2'd0, 32'h0,         1, 32'hC,         1, TAG | 32'h8,  32'hC);
        tv[3]  = mk(0, 2'd1, 32'h40,        1, 32'h40,        0, NOP,          32'hC);
        tv[4]  = mk(0, 2'd0, 32'h0,         1, 32'h44,        1, TAG | 32'h40, 32'h44);
        tv[5]  = mk(1, 2'd1, 32'h300,       0, 32'h0,         1, TAG | 32'h40, 32'h44);
        tv[6]  = mk(1, 2'd3, 32'h200,       0, 32'h0,         1, TAG | 32'h40, 32'h44);
        tv[7]  = mk(1, 2'd0, 32'h0,         0, 32'h0,         1, TAG | 32'h40, 32'h44);
        tv[8]  = mk(1, 2'd0, 32'h0,         0, 32'h0,         1, TAG | 32'h40, 32'h44);
        tv[9]  = mk(0, 2'd0, 32'h0,         1, 32'h48,        1, TAG | 32'h44, 32'h48);
        tv[10] = mk(0, 2'd0, 32'h0,         1, 32'h4C,        1, TAG | 32'h48, 32'h4C);
        tv[11] = mk(1, 2'd0, 32'h0,         0, 32'h0,         1, TAG | 32'h48, 32'h4C);
        tv[12] = mk(0, 2'd2, 32'h80,        1, 32'h80,        0, NOP,          32'h4C);
        tv[13] = mk(0, 2'd0, 32'h0,         1, 32'h84,        1, TAG | 32'h80, 32'h84);
        tv[14] = mk(0, 2'd3, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0, NOP,          32'h84);
        tv[15] = mk(0, 2'd0, 32'h0,         1, 32'h0,         1, 32'hFFFF_FFFC, 32'h0);
        tv[16] = mk(0, 2'd0, 32'h0,         1, 32'h4,         1, TAG | 32'h0,  32'h4);

        // reset state
        lat_cfg = 1;
        do_reset();
        clrn = 1'b0;
        step();
        chk("rst req",   {31'd0, imem_req}, 32'd0);
        chk("rst valid", {31'd0, if_valid}, 32'd0);
        chk("rst inst",  if_inst, NOP);
        chk("rst pc4",   if_pc4, 32'd0);
        clrn = 1'b1;
        step();
        chk("first req",   {31'd0, imem_req}, 32'd1);
        chk("first addr",  imem_addr, 32'h0);
        chk("first valid", {31'd0, if_valid}, 32'd0);

        foreach (tv[i]) begin
            drive(tv[i].stall, tv[i].ps, tv[i].tgt);
            step();
            chk($sformatf("row%0d req", i), {31'd0, imem_req}, {31'd0, tv[i].exp_req});
            if (tv[i].exp_req)
                chk($sformatf("row%0d addr", i), imem_addr, tv[i].exp_addr);
            chk($sformatf("row%0d valid", i), {31'd0, if_valid}, {31'd0, tv[i].exp_vld});
            chk($sformatf("row%0d inst", i), if_inst, tv[i].exp_inst);
            chk($sformatf("row%0d pc4", i), if_pc4, tv[i].exp_pc4);
        end

        // 3-cycle memory: address held for three cycles, one valid instruction every three cycles
        lat_cfg = 3;
        do_reset();
        for (int k = 1; k <= 9; k++) begin
            step();
            chk($sformatf("lat3 c%0d addr", k), imem_addr, 32'(4 * ((k - 1) / 3)));
            if (k >= 4 && ((k - 1) % 3) == 0) begin
                chk($sformatf("lat3 c%0d valid", k), {31'd0, if_valid}, 32'd1);
                chk($sformatf("lat3 c%0d inst", k), if_inst, TAG | 32'(4 * ((k - 1) / 3 - 1)));
                chk($sformatf("lat3 c%0d pc4", k), if_pc4, 32'(4 * ((k - 1) / 3)));
            end else begin
                chk($sformatf("lat3 c%0d valid", k), {31'd0, if_valid}, 32'd0);
                chk($sformatf("lat3 c%0d inst", k), if_inst, NOP);
            end
        end

        // 2-cycle memory: redirect while the fetch of 8 is outstanding
        lat_cfg = 2;
        do_reset();
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            if (if_valid && if_pc4 == 32'h8) found = 1'b1;
        end
        chk("drop setup found", {31'd0, found}, 32'd1);
        drive(0, 2'd3, 32'h100);
        step();
        chk("drop req",   {31'd0, imem_req}, 32'd1);
        chk("drop addr",  imem_addr, 32'h8);
        chk("drop valid", {31'd0, if_valid}, 32'd0);
        drive(0, 2'd0, 32'h0);
        step();
        chk("drop new addr", imem_addr, 32'h100);
        found     = 1'b0;
        saw_wrong = 1'b0;
        for (int k = 0; k < 12 && !found; k++) begin
            if (if_valid && if_pc4 == 32'hC) saw_wrong = 1'b1;
            if (if_valid && if_pc4 == 32'h104) found = 1'b1;
            else step();
        end
        chk("drop no wrong-path", {31'd0, saw_wrong}, 32'd0);
        chk("drop target found", {31'd0, found}, 32'd1);
        chk("drop target inst", if_inst, TAG | 32'h100);

        // reset mid-fetch with IF/ID valid
        lat_cfg = 1;
        do_reset();
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            if (if_valid && imem_req && imem_addr == 32'h20) found = 1'b1;
        end
        chk("midrst setup found", {31'd0, found}, 32'd1);
        clrn = 1'b0;
        step();
        chk("midrst valid", {31'd0, if_valid}, 32'd0);
        chk("midrst inst",  if_inst, NOP);
        chk("midrst req",   {31'd0, imem_req}, 32'd0);
        chk("midrst pc4",   if_pc4, 32'd0);
        clrn = 1'b1;
        step();
        chk("midrst restart addr", imem_addr, 32'h0);
        chk("midrst restart req",  {31'd0, imem_req}, 32'd1);
        step();
        chk("midrst first valid", {31'd0, if_valid}, 32'd1);
        chk("midrst first inst",  if_inst, TAG);

        // random stalls, redirects and memory latency against an architectural next-PC model
        rnd_lat = 1'b1;
        do_reset();
        exp_pc    = 32'h0;
        consumed  = 0;
        prev_pend = 1'b0;
        prev_addr = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            stall_en = ($urandom_range(0, 3) == 0);
            pcsource = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            bpc = 32'($urandom_range(0, 1023)) << 2;
            ra  = 32'($urandom_range(0, 1023)) << 2;
            jpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FF00 + (32'($urandom_range(0, 63)) << 2)
                                              : 32'($urandom_range(0, 1023)) << 2;
            if (prev_pend)
                chk("rand req stable", {imem_req, imem_addr[30:0]}, {1'b1, prev_addr[30:0]});
            if (if_valid && !stall_en) begin
                chk("rand pc", if_pc4 - 32'd4, exp_pc);
                chk("rand inst", if_inst, (if_pc4 - 32'd4) | TAG);
                case (pcsource)
                    2'b01:   nxt = bpc;
                    2'b10:   nxt = ra;
                    2'b11:   nxt = jpc;
                    default: nxt = if_pc4;
                endcase
                exp_pc = nxt;
                consumed++;
            end
            prev_pend = imem_req && !imem_ack;
            prev_addr = imem_addr;
            step();
        end
        chk("rand progress", {31'd0, consumed >= 300}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
